// File: rtl/vp_pkg.sv
// Shared encodings for the VP filter-control blocks: output modes and control-FSM states.
package vp_pkg;

    localparam logic [1:0] MODE_BYPASS = 2'd0;
    localparam logic [1:0] MODE_MEDIAN = 2'd1;
    localparam logic [1:0] MODE_BORDER = 2'd2;
    localparam logic [1:0] MODE_RSVD   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FRAME = 2'd1,
        ST_LINE  = 2'd2
    } ctrl_state_e;

    // Reserved mode 3 is treated as a plain median pass.
    function automatic logic mode_uses_border(input logic [1:0] mode);
        return (mode == MODE_BORDER);
    endfunction

endpackage

// File: rtl/vp_delay_line.sv
// Free-running WIDTH x DEPTH shift register; dout is din delayed by DEPTH clocks.
// Advances every clock, no enable and no backpressure.
module vp_delay_line #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] tap_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) tap_q[i] <= '0;
        end else begin
            tap_q[0] <= din;
            for (int i = 1; i < DEPTH; i++) tap_q[i] <= tap_q[i-1];
        end
    end

    assign dout = tap_q[DEPTH-1];

endmodule

// File: rtl/median_ctrl.sv
// Frame-level bypass/median/border-mask select for the luma median path; 1-clock output latency.
// Mode changes apply only at frame start. Optional MEDIAN_CTRL_STATS_EN builds geometry-error and frame counters.
module median_ctrl
    import vp_pkg::*;
#(
    parameter logic [10:0] IMG_HDISP = 11'd1280,
    parameter logic [9:0]  IMG_VDISP = 10'd720,
    parameter int          FILT_LAT  = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] per_y,
    input  logic       filt_frame_vsync,
    input  logic       filt_frame_href,
    input  logic       filt_frame_clken,
    input  logic [7:0] filt_y,
    input  logic [1:0] cfg_mode,
    input  logic       cfg_wr,
    output logic       cfg_busy,
    output logic [1:0] active_mode,
    output logic       post_frame_vsync,
    output logic       post_frame_href,
    output logic       post_frame_clken,
    output logic [7:0] post_y,
    input  logic       err_clr,
    output logic       line_err,
    output logic       frame_err,
    output logic [7:0] frame_cnt
);

    ctrl_state_e state_q;
    logic        vs_prev_q, hs_prev_q, armed_q;
    logic [1:0]  pend_mode_q, active_mode_q;
    logic        busy_q;
    logic [10:0] col_q, col_d;
    logic [9:0]  row_q, row_d;
    logic        pvs_q, phs_q, pce_q;
    logic [7:0]  post_y_q, post_y_d;
    logic [7:0]  byp_y;

    logic        vs_rise, vs_fall, hs_rise, hs_fall, in_line, live;
    logic [10:0] pix_col;
    logic [9:0]  pix_row;
    logic [1:0]  mode_eff;
    logic        on_border;

    vp_delay_line #(
        .WIDTH (8),
        .DEPTH (FILT_LAT)
    ) u_byp_dly (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (per_y),
        .dout  (byp_y)
    );

    // armed_q demands vsync be seen low after reset, so a frame already in flight is never picked up.
    assign vs_rise = (state_q == ST_IDLE) & armed_q & filt_frame_vsync & ~vs_prev_q;
    assign vs_fall = (state_q != ST_IDLE) & ~filt_frame_vsync;
    assign hs_rise = filt_frame_href & ~hs_prev_q &
                     (vs_rise | ((state_q == ST_FRAME) & filt_frame_vsync));
    assign hs_fall = (state_q == ST_LINE) & ~filt_frame_href;
    assign in_line = hs_rise | ((state_q == ST_LINE) & filt_frame_vsync & filt_frame_href);
    assign live    = vs_rise | ((state_q != ST_IDLE) & filt_frame_vsync);

    assign pix_col  = hs_rise ? 11'd0 : col_q;
    assign pix_row  = vs_rise ? 10'd0 : row_q;
    assign mode_eff = (vs_rise & busy_q) ? pend_mode_q : active_mode_q;

    assign on_border = (pix_row == 10'd0) || (pix_row == IMG_VDISP - 10'd1) ||
                       (pix_col == 11'd0) || (pix_col == IMG_HDISP - 11'd1);

    always_comb begin
        col_d = col_q;
        if (hs_rise) col_d = '0;
        if (in_line && filt_frame_clken && (col_d != '1)) col_d = col_d + 11'd1;
    end

    always_comb begin
        row_d = row_q;
        if (vs_rise) row_d = '0;
        else if (hs_fall && (row_q != '1)) row_d = row_q + 10'd1;
    end

    always_comb begin
        post_y_d = post_y_q;
        if (filt_frame_clken && live) begin
            if (mode_eff == MODE_BYPASS)
                post_y_d = byp_y;
            else if (mode_uses_border(mode_eff) && on_border)
                post_y_d = 8'd0;
            else
                post_y_d = filt_y;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  if (vs_rise) state_q <= hs_rise ? ST_LINE : ST_FRAME;
                ST_FRAME: if (vs_fall) state_q <= ST_IDLE;
                          else if (hs_rise) state_q <= ST_LINE;
                ST_LINE:  if (vs_fall) state_q <= ST_IDLE;
                          else if (hs_fall) state_q <= ST_FRAME;
                default:  state_q <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_prev_q <= 1'b0;
            hs_prev_q <= 1'b0;
            armed_q   <= 1'b0;
            col_q     <= '0;
            row_q     <= '0;
            pvs_q     <= 1'b0;
            phs_q     <= 1'b0;
            pce_q     <= 1'b0;
            post_y_q  <= '0;
        end else begin
            vs_prev_q <= filt_frame_vsync;
            hs_prev_q <= filt_frame_href;
            if (!filt_frame_vsync) armed_q <= 1'b1;
            col_q     <= col_d;
            row_q     <= row_d;
            pvs_q     <= filt_frame_vsync & live;
            phs_q     <= filt_frame_href  & live;
            pce_q     <= filt_frame_clken & live;
            post_y_q  <= post_y_d;
        end
    end

    // A write in the frame-start clock lands in pend after the old pend has been applied.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_mode_q   <= MODE_BYPASS;
            active_mode_q <= MODE_BYPASS;
            busy_q        <= 1'b0;
        end else begin
            if (vs_rise && busy_q) begin
                active_mode_q <= pend_mode_q;
                busy_q        <= 1'b0;
            end
            if (cfg_wr) begin
                pend_mode_q <= cfg_mode;
                busy_q      <= 1'b1;
            end
        end
    end

    assign cfg_busy         = busy_q;
    assign active_mode      = active_mode_q;
    assign post_frame_vsync = pvs_q;
    assign post_frame_href  = phs_q;
    assign post_frame_clken = pce_q;
    assign post_y           = post_y_q;

`ifdef MEDIAN_CTRL_STATS_EN
    logic        line_err_q, frame_err_q;
    logic [7:0]  frame_cnt_q;
    logic [10:0] col_fin;

    // A pixel strobe in the href-fall clock still belongs to the ending line.
    assign col_fin = (filt_frame_clken && (col_q != '1)) ? col_q + 11'd1 : col_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_err_q  <= 1'b0;
            frame_err_q <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            if (hs_fall && (col_fin != IMG_HDISP)) line_err_q <= 1'b1;
            else if (err_clr)                      line_err_q <= 1'b0;
            if (vs_fall && (row_q != IMG_VDISP))   frame_err_q <= 1'b1;
            else if (err_clr)                      frame_err_q <= 1'b0;
            if (vs_fall) frame_cnt_q <= frame_cnt_q + 8'd1;
        end
    end

    assign line_err  = line_err_q;
    assign frame_err = frame_err_q;
    assign frame_cnt = frame_cnt_q;
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign line_err  = 1'b0;
    assign frame_err = 1'b0;
    assign frame_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_median_ctrl.sv
// Directed bench for median_ctrl with a pixel scoreboard and a small mode/statistics model.
module tb_median_ctrl;

    localparam logic [10:0] HD  = 11'd8;
    localparam logic [9:0]  VD  = 10'd4;
    localparam int          LAT = 3;
`ifdef MEDIAN_CTRL_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] per_y = '0;
    logic       filt_frame_vsync = 1'b0, filt_frame_href = 1'b0, filt_frame_clken = 1'b0;
    logic [7:0] filt_y = '0;
    logic [1:0] cfg_mode = '0;
    logic       cfg_wr = 1'b0, err_clr = 1'b0;
    logic       cfg_busy, post_frame_vsync, post_frame_href, post_frame_clken;
    logic [1:0] active_mode;
    logic [7:0] post_y, frame_cnt;
    logic       line_err, frame_err;

    always #5 clk = ~clk;

    median_ctrl #(.IMG_HDISP(HD), .IMG_VDISP(VD), .FILT_LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .per_y(per_y),
        .filt_frame_vsync(filt_frame_vsync), .filt_frame_href(filt_frame_href),
        .filt_frame_clken(filt_frame_clken), .filt_y(filt_y),
        .cfg_mode(cfg_mode), .cfg_wr(cfg_wr), .cfg_busy(cfg_busy), .active_mode(active_mode),
        .post_frame_vsync(post_frame_vsync), .post_frame_href(post_frame_href),
        .post_frame_clken(post_frame_clken), .post_y(post_y),
        .err_clr(err_clr), .line_err(line_err), .frame_err(frame_err), .frame_cnt(frame_cnt)
    );

    int checks = 0, errors = 0;
    int tcnt = 0;
    logic [7:0] sb [$];
    logic [7:0] mon_exp;

    logic [1:0] m_pend = 0, m_active = 0;
    logic       m_busy = 0, m_armed = 0, m_vs_prev = 0, m_infr = 0;
    logic       m_lerr = 0, m_ferr = 0;
    int         m_frames = 0;
    logic       wr_nxt = 0, clr_nxt = 0;
    logic [1:0] mode_nxt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] fy(input int r, input int c);
        return 8'h80 + 8'(r * 16 + c);
    endfunction

    // One pixel clock: drive inputs, advance the model, push any expected output pixel.
    task automatic cyc(input logic vs, input logic hs, input logic ce,
                       input logic [7:0] fyv, input int r, input int c);
        logic rise;
        logic [1:0] me;
        logic [7:0] e;
        filt_frame_vsync = vs; filt_frame_href = hs; filt_frame_clken = ce;
        filt_y = fyv; per_y = tcnt[7:0];
        cfg_wr = wr_nxt; cfg_mode = mode_nxt; err_clr = clr_nxt;
        rise = vs && !m_vs_prev && m_armed && !m_infr;
        me = (rise && m_busy) ? m_pend : m_active;
        if (ce && (m_infr || rise)) begin
            if (me == 2'd0)
                e = 8'(tcnt - LAT);
            else if (me == 2'd2 && (r == 0 || r == int'(VD) - 1 || c == 0 || c == int'(HD) - 1))
                e = 8'h00;
            else
                e = fyv;
            sb.push_back(e);
        end
        if (rise && m_busy) begin m_active = m_pend; m_busy = 1'b0; end
        if (wr_nxt) begin m_pend = mode_nxt; m_busy = 1'b1; end
        if (clr_nxt) begin m_lerr = 1'b0; m_ferr = 1'b0; end
        if (rise) m_infr = 1'b1;
        if (!vs) begin m_infr = 1'b0; m_armed = 1'b1; end
        m_vs_prev = vs;
        wr_nxt = 1'b0; clr_nxt = 1'b0;
        @(posedge clk); #1;
        tcnt++;
    endtask

    // wr_ln: -2 none, -1 in the vsync-rise clock, >=0 at pixel 0 of that line.
    task automatic frame(input int nl, input int short_ln, input int wr_ln, input logic [1:0] wr_md);
        int np;
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 8'h00, 0, 0);
        if (wr_ln == -1) begin wr_nxt = 1'b1; mode_nxt = wr_md; end
        cyc(1, 0, 0, 8'h00, 0, 0);
        for (int r = 0; r < nl; r++) begin
            np = (r == short_ln) ? int'(HD) - 1 : int'(HD);
            for (int c = 0; c < np; c++) begin
                if (wr_ln == r && c == 0) begin wr_nxt = 1'b1; mode_nxt = wr_md; end
                cyc(1, 1, 1, fy(r, c), r, c);
            end
            if (STATS && np != int'(HD)) m_lerr = 1'b1;
            cyc(1, 0, 0, 8'h00, r, 0);
            cyc(1, 0, 0, 8'h00, r, 0);
        end
        cyc(0, 0, 0, 8'h00, 0, 0);
        if (STATS) begin
            m_frames++;
            if (nl != int'(VD)) m_ferr = 1'b1;
        end
        cyc(0, 0, 0, 8'h00, 0, 0);
    endtask

    task automatic chk_status(input string tag);
        chk({tag, "_busy"}, 32'(cfg_busy), 32'(m_busy));
        chk({tag, "_mode"}, 32'(active_mode), 32'(m_active));
        chk({tag, "_lerr"}, 32'(line_err), 32'(m_lerr));
        chk({tag, "_ferr"}, 32'(frame_err), 32'(m_ferr));
        chk({tag, "_fcnt"}, 32'(frame_cnt), 32'(m_frames[7:0]));
    endtask

    task automatic model_reset();
        m_pend = 0; m_active = 0; m_busy = 0; m_armed = 0; m_vs_prev = 0; m_infr = 0;
        m_lerr = 0; m_ferr = 0; m_frames = 0;
    endtask

    always @(negedge clk) begin
        if (rst_n && post_frame_clken) begin
            if (sb.size() == 0) begin
                checks++; errors++;
                $error("FAIL pix_unexpected observed=%0h expected=none", post_y);
            end else begin
                mon_exp = sb.pop_front();
                chk("pix", 32'(post_y), 32'(mon_exp));
                chk("pix_vsync", 32'(post_frame_vsync), 32'd1);
            end
        end
    end

    initial begin
        #1;
        chk("rst_post_y", 32'(post_y), 32'd0);
        chk("rst_vsync", 32'(post_frame_vsync), 32'd0);
        chk("rst_clken", 32'(post_frame_clken), 32'd0);
        chk_status("rst");
        repeat (2) cyc(0, 0, 0, 8'h00, 0, 0);
        rst_n = 1'b1;
        repeat (4) cyc(0, 0, 0, 8'h00, 0, 0);

        frame(4, -1, -2, 2'd0);
        chk_status("byp");
        chk("byp_fcnt_lit", 32'(frame_cnt), STATS ? 32'd1 : 32'd0);

        frame(4, -1, 1, 2'd1);
        chk_status("wr_mid");
        chk("wr_mid_busy_lit", 32'(cfg_busy), 32'd1);

        frame(4, -1, -2, 2'd0);
        chk_status("median");
        chk("median_mode_lit", 32'(active_mode), 32'd1);

        wr_nxt = 1'b1; mode_nxt = 2'd2;
        cyc(0, 0, 0, 8'h00, 0, 0);
        frame(4, -1, -2, 2'd0);
        chk_status("border");

        frame(4, 2, -2, 2'd0);
        chk_status("short_line");
        clr_nxt = 1'b1;
        cyc(0, 0, 0, 8'h00, 0, 0);
        cyc(0, 0, 0, 8'h00, 0, 0);
        chk_status("clr1");
        frame(3, -1, -2, 2'd0);
        chk_status("short_frame");
        clr_nxt = 1'b1;
        cyc(0, 0, 0, 8'h00, 0, 0);
        chk_status("clr2");

        wr_nxt = 1'b1; mode_nxt = 2'd2;
        cyc(0, 0, 0, 8'h00, 0, 0);
        wr_nxt = 1'b1; mode_nxt = 2'd1;
        cyc(0, 0, 0, 8'h00, 0, 0);
        frame(4, -1, -2, 2'd0);
        chk_status("last_wins");
        chk("last_wins_lit", 32'(active_mode), 32'd1);

        wr_nxt = 1'b1; mode_nxt = 2'd2;
        cyc(0, 0, 0, 8'h00, 0, 0);
        frame(4, -1, -1, 2'd3);
        chk_status("wr_at_rise");
        frame(4, -1, -2, 2'd0);
        chk_status("reserved");

        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 8'h00, 0, 0);
        cyc(1, 0, 0, 8'h00, 0, 0);
        for (int c = 0; c < 4; c++) cyc(1, 1, 1, fy(0, c), 0, c);
        @(negedge clk); #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("mid_rst_post_y", 32'(post_y), 32'd0);
        chk("mid_rst_href", 32'(post_frame_href), 32'd0);
        chk("mid_rst_clken", 32'(post_frame_clken), 32'd0);
        chk_status("mid_rst");
        cyc(1, 1, 1, fy(0, 4), 0, 4);
        cyc(1, 1, 1, fy(0, 5), 0, 5);
        rst_n = 1'b1;
        cyc(1, 1, 1, fy(0, 6), 0, 6);
        cyc(1, 1, 1, fy(0, 7), 0, 7);
        cyc(1, 0, 0, 8'h00, 0, 0);
        chk("post_rst_vsync", 32'(post_frame_vsync), 32'd0);
        chk("post_rst_post_y", 32'(post_y), 32'd0);
        frame(4, -1, -2, 2'd0);
        chk_status("after_rst");
        chk("after_rst_fcnt_lit", 32'(frame_cnt), STATS ? 32'd1 : 32'd0);

        repeat (2) cyc(0, 0, 0, 8'h00, 0, 0);
        chk("sb_drain", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

endmodule
